writeback_unit: RTL and testbench
=================================

# writeback_unit

Writeback stage and register scoreboard placed directly upstream of the register file. It merges single-cycle ALU results and long-latency load responses into the register file's single write port. Every register write leaves this block from a registered output. It tracks which architectural registers have a load outstanding and stalls decode on RAW and WAW hazards against them.

## Interface
- MEM_Q_DEPTH, 2, load-response queue depth; power of two, ≥2
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- issue_valid  in  1  decode presents an instruction
- issue_rs1, issue_rs2  in  5  source registers of the presented instruction
- issue_rd  in  5  destination register of the presented instruction
- issue_rd_long  in  1  rd is produced by a load (long-latency path)
- issue_stall  out  1  combinational; the instruction must not issue this cycle
- alu_valid  in  1  ALU result present this cycle; no handshake, always taken
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  load response valid
- mem_ready  out  1  combinational; equals count < MEM_Q_DEPTH
- mem_rd  in  5  load destination register
- mem_data  in  32  load data
- rf_write_en, rf_rd_addr, rf_rd_data  out  1/5/32  registered write port to the register file
- byp_rs1_sel, byp_rs2_sel  out  1  decode takes rf_rd_data for rs1 / rs2 (see Configuration)

## Operation
- Scoreboard: 32-bit pending vector; bit 0 is constant 0.
  - Issue accepted = issue_valid && !issue_stall.
  - On an accepted issue with issue_rd_long and issue_rd≠0, set pending[issue_rd] at the clock edge.
- issue_stall = issue_valid && (pending[rs1] || pending[rs2] || pending[rd]), after the bypass masking described in Configuration.
  - Consequence: the ALU never targets a pending register, and set and clear of the same bit never coincide.
- Load queue: a FIFO of {rd, data}.
  - Push on mem_valid && mem_ready, unless the response is taken directly (see the source-select rule below).
  - A response with mem_rd=0 is accepted and discarded: no push, no write.
- Source select, one per cycle, in strict priority order:
  - ALU, when alu_valid && alu_rd≠0. alu_valid with alu_rd=0 is treated as idle.
  - Queue head, which is popped.
  - Incoming mem response when the queue is empty (direct path; no push).
- Selected {1, rd, data} is registered onto rf_*. With no selection, rf_write_en=0 next cycle and rf_rd_addr/rf_rd_data hold their values.
- An internal flag records whether the current rf_* write came from the mem path.
  - On the edge where rf_write_en=1 with the flag set, clear pending[rf_rd_addr].
- Queue full: mem_ready=0. A pop and a push in the same cycle are allowed; the count is unchanged.
- ALU can starve the queue indefinitely. The upstream pipeline guarantees bubbles.

## Timing
- ALU or direct mem result: selected in cycle N, rf_write_en high in N+1, register file updated at the end of N+1. A dependent instruction reads the correct value in N+2.
- Queued load waits one cycle per preceding ALU winner.
- Without WB_BYPASS_EN, a dependent instruction's stall drops in cycle N+2, the cycle after rf_write_en.
- Reset values:
  - pending=0, queue empty.
  - rf_write_en=0, rf_rd_addr=0, rf_rd_data=0.
  - byp_rs*_sel=0, issue_stall=0 (with issue_valid low).
  - mem_ready=1.
- Reset mid-operation: pending and queue cleared immediately. Queued and in-flight loads are lost; the memory side is reset in the same cycle.

## Configuration
- WB_BYPASS_EN defined: a pending source register equal to rf_rd_addr, while rf_write_en=1 with the mem flag set, does not stall.
  - The corresponding byp_rsX_sel=1 in that cycle.
  - Decode forwards rf_rd_data, and the load-use penalty drops by one cycle.
  - WAW is still stalled on pending[rd].
- WB_BYPASS_EN undefined: byp_rs1_sel and byp_rs2_sel are tied to 0, and stall uses the pending vector only.

## Test plan
- Reset release: all outputs at their reset values; mem_ready=1. ALU x5=0x12345678 in cycle 1 → rf_write_en=1, rf_rd_addr=5, rf_rd_data=0x12345678 in cycle 2.
- Issue load x7. Then issue an instruction with rs1=7 → stalled. Response 0xDEADBEEF arrives on an idle cycle → rf write x7 next cycle; stall drops one cycle later, or in the rf_write_en cycle with byp_rs1_sel=1 when WB_BYPASS_EN is defined.
- ALU x3 and mem x9 arrive in the same cycle → x3 written first, x9 the following cycle from the queue.
- Continuous alu_valid for 4 cycles with 3 mem responses, MEM_Q_DEPTH=2 → mem_ready=0 after 2 pushes. Queue drains in order once alu_valid drops; no response is lost or duplicated.
- ALU x0 write and mem x0 response → rf_write_en stays 0; pending is never set for x0; issue of rd=0 with issue_rd_long never stalls later issues.
- rst asserted with 2 queued loads and pending bits set → queue empty, pending=0, rf_write_en=0 on the same cycle.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback merge of ALU results and queued/direct load data into one registered RF write port, plus a load scoreboard.
// One-cycle select-to-write latency; mem_ready drops when the load queue is full; optional WB_BYPASS_EN forwards the load being written.
module writeback_unit #(
  parameter int MEM_Q_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_long,
  output logic        issue_stall,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        rf_write_en,
  output logic [4:0]  rf_rd_addr,
  output logic [31:0] rf_rd_data,
  output logic        byp_rs1_sel,
  output logic        byp_rs2_sel
);

  localparam int AW = (MEM_Q_DEPTH > 1) ? $clog2(MEM_Q_DEPTH) : 1;

  logic [31:0]   r_pending;
  logic [4:0]    r_q_rd   [MEM_Q_DEPTH];
  logic [31:0]   r_q_data [MEM_Q_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_rf_we;
  logic [4:0]    r_rf_addr;
  logic [31:0]   r_rf_data;
  logic          r_from_mem;

  logic        w_q_empty;
  logic        w_alu_take;
  logic        w_mem_take;
  logic        w_pop;
  logic        w_push;
  logic        w_direct;
  logic        w_issue_acc;
  logic        w_byp1;
  logic        w_byp2;
  logic        w_sel_vld;
  logic        w_sel_mem;
  logic [4:0]  w_sel_rd;
  logic [31:0] w_sel_data;
  logic [31:0] w_pending_nxt;

  assign w_q_empty  = (r_count == '0);
  assign mem_ready  = (r_count < (AW+1)'(MEM_Q_DEPTH));
  assign w_alu_take = alu_valid && (alu_rd != 5'd0);
  // Responses to x0 are accepted but never reach the queue or the RF.
  assign w_mem_take = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign w_pop      = !w_alu_take && !w_q_empty;
  assign w_direct   = !w_alu_take && w_q_empty && w_mem_take;
  assign w_push     = w_mem_take && !w_direct;

`ifdef WB_BYPASS_EN
  logic w_mem_wb;
  assign w_mem_wb = r_rf_we && r_from_mem;
  assign w_byp1   = w_mem_wb && (issue_rs1 == r_rf_addr) && r_pending[issue_rs1];
  assign w_byp2   = w_mem_wb && (issue_rs2 == r_rf_addr) && r_pending[issue_rs2];
`else
  assign w_byp1   = 1'b0;
  assign w_byp2   = 1'b0;
`endif

  assign byp_rs1_sel = w_byp1;
  assign byp_rs2_sel = w_byp2;
  // WAW on rd is never forwarded away.
  assign issue_stall = issue_valid && ((r_pending[issue_rs1] && !w_byp1) ||
                                       (r_pending[issue_rs2] && !w_byp2) ||
                                       r_pending[issue_rd]);
  assign w_issue_acc = issue_valid && !issue_stall;

  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_mem  = 1'b0;
    w_sel_rd   = r_q_rd[r_rptr];
    w_sel_data = r_q_data[r_rptr];
    if (w_alu_take) begin
      w_sel_vld  = 1'b1;
      w_sel_rd   = alu_rd;
      w_sel_data = alu_data;
    end else if (!w_q_empty) begin
      w_sel_vld  = 1'b1;
      w_sel_mem  = 1'b1;
    end else if (w_mem_take) begin
      w_sel_vld  = 1'b1;
      w_sel_mem  = 1'b1;
      w_sel_rd   = mem_rd;
      w_sel_data = mem_data;
    end
  end

  always_comb begin
    w_pending_nxt = r_pending;
    if (r_rf_we && r_from_mem) begin
      w_pending_nxt[r_rf_addr] = 1'b0;
    end
    if (w_issue_acc && issue_rd_long && (issue_rd != 5'd0)) begin
      w_pending_nxt[issue_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wptr]   <= mem_rd;
      r_q_data[r_wptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_data  <= '0;
      r_from_mem <= 1'b0;
    end else begin
      r_rf_we    <= w_sel_vld;
      r_from_mem <= w_sel_mem;
      if (w_sel_vld) begin
        r_rf_addr <= w_sel_rd;
        r_rf_data <= w_sel_data;
      end
    end
  end

  assign rf_write_en = r_rf_we;
  assign rf_rd_addr  = r_rf_addr;
  assign rf_rd_data  = r_rf_data;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: vector table, directed hazard/queue/reset sequences, then random traffic vs a queue-based model.
module tb_writeback_unit;

  localparam int DEPTH = 2;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_rd_long;
  logic        issue_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        rf_write_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        byp_rs1_sel, byp_rs2_sel;

  always #5 clk = ~clk;

  writeback_unit #(.MEM_Q_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_rd_long(issue_rd_long), .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_write_en(rf_write_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .byp_rs1_sel(byp_rs1_sel), .byp_rs2_sel(byp_rs2_sel)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        rdy;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  vec_t        vt [9];
  ent_t        m_q [$];
  ent_t        m_out [$];
  ent_t        e;
  bit          m_pend [32];
  logic        m_we, m_mem, n_we, n_mem;
  logic [4:0]  m_addr, n_addr;
  logic [31:0] m_data, n_data;
  bit          e_b1, e_b2, e_stall, e_rdy, acc, direct;
  logic [4:0]  w_rd [$];
  logic [31:0] w_d [$];
  int          sent;
  bit          exp_rdy [8];
  logic [4:0]  exp_rd [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_rd_long = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic lng);
    issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_rd_long = lng;
  endtask

  initial begin
    vt[0] = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd5,  32'h12345678};
    vt[1] = '{1'b0, 5'd7,  32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd5,  32'h12345678};
    vt[2] = '{1'b1, 5'd0,  32'hAAAA5555, 1'b1, 5'd0, 32'h0BAD0BAD, 1'b1, 1'b0, 5'd5,  32'h12345678};
    vt[3] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd31, 32'hCAFEF00D};
    vt[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'h00000099, 1'b1, 1'b1, 5'd9,  32'h00000099};
    vt[5] = '{1'b1, 5'd3,  32'h33333333, 1'b1, 5'd9, 32'h99999999, 1'b1, 1'b1, 5'd3,  32'h33333333};
    vt[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd9,  32'h99999999};
    vt[7] = '{1'b1, 5'd1,  32'h0,        1'b1, 5'd0, 32'h00000011, 1'b1, 1'b1, 5'd1,  32'h0};
    vt[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd1,  32'h0};

    // Reset values
    do_reset();
    chk("rst_we",    32'(rf_write_en), 32'(1'b0));
    chk("rst_addr",  32'(rf_rd_addr),  32'(5'd0));
    chk("rst_data",  rf_rd_data,       32'h0);
    chk("rst_stall", 32'(issue_stall), 32'(1'b0));
    chk("rst_byp1",  32'(byp_rs1_sel), 32'(1'b0));
    chk("rst_byp2",  32'(byp_rs2_sel), 32'(1'b0));
    chk("rst_ready", 32'(mem_ready),   32'(1'b1));

    // Vector table
    for (int i = 0; i < 9; i++) begin
      idle();
      alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].ad;
      mem_valid = vt[i].mv; mem_rd = vt[i].mrd; mem_data = vt[i].md;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(mem_ready), 32'(vt[i].rdy));
      tick();
      chk($sformatf("vec%0d_we", i),   32'(rf_write_en), 32'(vt[i].we));
      chk($sformatf("vec%0d_addr", i), 32'(rf_rd_addr),  32'(vt[i].addr));
      chk($sformatf("vec%0d_data", i), rf_rd_data,       vt[i].data);
    end

    // Load-use stall on x7
    idle();
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    #1 chk("ld7_issue_stall", 32'(issue_stall), 32'(1'b0));
    tick();
    issue(5'd7, 5'd2, 5'd8, 1'b0);
    #1 chk("raw7_stall_a", 32'(issue_stall), 32'(1'b1));
    tick();
    #1 chk("raw7_stall_b", 32'(issue_stall), 32'(1'b1));
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hDEADBEEF;
    #1 chk("raw7_stall_resp", 32'(issue_stall), 32'(1'b1));
    tick();
    mem_valid = 1'b0;
    chk("ld7_we",   32'(rf_write_en), 32'(1'b1));
    chk("ld7_addr", 32'(rf_rd_addr),  32'(5'd7));
    chk("ld7_data", rf_rd_data,       32'hDEADBEEF);
    #1;
    chk("raw7_stall_wb", 32'(issue_stall), 32'(!BYP));
    chk("raw7_byp1_wb",  32'(byp_rs1_sel), 32'(BYP));
    chk("raw7_byp2_wb",  32'(byp_rs2_sel), 32'(1'b0));
    tick();
    chk("raw7_stall_after", 32'(issue_stall), 32'(1'b0));
    chk("raw7_byp1_after",  32'(byp_rs1_sel), 32'(1'b0));
    chk("ld7_we_after",     32'(rf_write_en), 32'(1'b0));

    // Queue fill under continuous ALU traffic, then in-order drain
    idle();
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_rd  = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd20, 5'd21, 5'd22};
    sent = 0;
    w_rd.delete(); w_d.delete();
    for (int c = 0; c < 8; c++) begin
      alu_valid = (c < 4); alu_rd = 5'(10 + c); alu_data = 32'(32'hA000 + c);
      mem_valid = (sent < 3); mem_rd = 5'(20 + sent); mem_data = 32'(32'hB000 + sent);
      #1 chk($sformatf("fill_ready_c%0d", c), 32'(mem_ready), 32'(exp_rdy[c]));
      if (mem_valid && mem_ready) sent++;
      tick();
      if (rf_write_en) begin
        w_rd.push_back(rf_rd_addr);
        w_d.push_back(rf_rd_data);
      end
    end
    chk("fill_sent", 32'(sent), 32'd3);
    chk("fill_nwrites", 32'(w_rd.size()), 32'd7);
    for (int k = 0; k < 7 && k < w_rd.size(); k++) begin
      chk($sformatf("fill_rd%0d", k), 32'(w_rd[k]), 32'(exp_rd[k]));
      chk($sformatf("fill_d%0d", k), w_d[k], (k < 4) ? 32'(32'hA000 + k) : 32'(32'hB000 + k - 4));
    end

    // x0 destinations
    idle();
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    #1 chk("x0_ld_stall", 32'(issue_stall), 32'(1'b0));
    tick();
    issue(5'd0, 5'd0, 5'd0, 1'b0);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5A5A5A5A;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hA5A5A5A5;
    #1 chk("x0_use_stall", 32'(issue_stall), 32'(1'b0));
    tick();
    idle();
    chk("x0_we", 32'(rf_write_en), 32'(1'b0));
    tick();
    chk("x0_we_late", 32'(rf_write_en), 32'(1'b0));

    // Reset while loads are queued and pending
    idle();
    issue(5'd0, 5'd0, 5'd4, 1'b1);
    tick();
    issue(5'd0, 5'd0, 5'd6, 1'b1);
    tick();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h10;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
    tick();
    alu_rd = 5'd11; alu_data = 32'h11;
    mem_rd = 5'd6; mem_data = 32'h66;
    tick();
    mem_valid = 1'b0;
    alu_rd = 5'd12; alu_data = 32'h12;
    issue(5'd4, 5'd6, 5'd4, 1'b0);
    #1;
    chk("mid_ready_full", 32'(mem_ready),   32'(1'b0));
    chk("mid_stall",      32'(issue_stall), 32'(1'b1));
    chk("mid_we_pre",     32'(rf_write_en), 32'(1'b1));
    rst = 1'b1;
    #1;
    chk("mid_rst_we",    32'(rf_write_en), 32'(1'b0));
    chk("mid_rst_addr",  32'(rf_rd_addr),  32'(5'd0));
    chk("mid_rst_ready", 32'(mem_ready),   32'(1'b1));
    chk("mid_rst_stall", 32'(issue_stall), 32'(1'b0));
    tick();
    rst = 1'b0;
    idle();
    tick();
    chk("mid_post_we", 32'(rf_write_en), 32'(1'b0));
    tick();
    chk("mid_post_we2", 32'(rf_write_en), 32'(1'b0));

    // Random traffic against the reference model
    do_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_q.delete(); m_out.delete();
    m_we = 1'b0; m_mem = 1'b0; m_addr = '0; m_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      issue_valid   = 1'($urandom_range(0, 1));
      issue_rs1     = 5'($urandom_range(0, 7));
      issue_rs2     = 5'($urandom_range(0, 7));
      issue_rd      = 5'($urandom_range(0, 7));
      issue_rd_long = (m_out.size() < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      alu_valid     = ($urandom_range(0, 3) == 0);
      alu_rd        = 5'($urandom_range(0, 31));
      alu_data      = $urandom;
      if (m_out.size() > 0 && $urandom_range(0, 1) == 1) begin
        mem_valid = 1'b1; mem_rd = m_out[0].rd; mem_data = m_out[0].d;
      end else begin
        mem_valid = 1'b0; mem_rd = 5'($urandom); mem_data = $urandom;
      end
      #1;
      e_b1 = BYP && m_we && m_mem && (m_addr == issue_rs1) && m_pend[issue_rs1];
      e_b2 = BYP && m_we && m_mem && (m_addr == issue_rs2) && m_pend[issue_rs2];
      e_stall = issue_valid && ((m_pend[issue_rs1] && !e_b1) || (m_pend[issue_rs2] && !e_b2) || m_pend[issue_rd]);
      e_rdy = (m_q.size() < DEPTH);
      chk("rnd_stall", 32'(issue_stall), 32'(e_stall));
      chk("rnd_ready", 32'(mem_ready),   32'(e_rdy));
      chk("rnd_byp1",  32'(byp_rs1_sel), 32'(e_b1));
      chk("rnd_byp2",  32'(byp_rs2_sel), 32'(e_b2));

      acc = mem_valid && e_rdy;
      direct = 1'b0;
      n_we = 1'b0; n_mem = 1'b0; n_addr = m_addr; n_data = m_data;
      if (alu_valid && alu_rd != 5'd0) begin
        n_we = 1'b1; n_addr = alu_rd; n_data = alu_data;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        n_we = 1'b1; n_mem = 1'b1; n_addr = e.rd; n_data = e.d;
      end else if (acc && mem_rd != 5'd0) begin
        direct = 1'b1;
        n_we = 1'b1; n_mem = 1'b1; n_addr = mem_rd; n_data = mem_data;
      end
      if (acc && mem_rd != 5'd0 && !direct) m_q.push_back('{mem_rd, mem_data});
      if (acc) void'(m_out.pop_front());
      if (m_we && m_mem) m_pend[m_addr] = 1'b0;
      if (issue_valid && !e_stall && issue_rd_long) begin
        if (issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
        m_out.push_back('{issue_rd, $urandom});
      end
      m_we = n_we; m_mem = n_mem; m_addr = n_addr; m_data = n_data;

      tick();
      chk("rnd_we",   32'(rf_write_en), 32'(m_we));
      chk("rnd_addr", 32'(rf_rd_addr),  32'(m_addr));
      chk("rnd_data", rf_rd_data,       m_data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
